// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants and types for the FIFO write arbiter and the FIFO it feeds.
package fifo_write_arbiter_pkg;

  localparam int DEFAULT_WIDTH     = 6;
  localparam int DEFAULT_NREQ      = 4;
  localparam int DEFAULT_MAX_BURST = 4;

  // Wide enough for a burst counter with MAX_BURST up to 16.
  localparam int DBG_CNT_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    state_t                 state;
    logic [DBG_CNT_W-1:0]   burst_cnt;
  } dbg_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle for the write arbiter.
interface fifo_write_arbiter_if #(
  parameter int WIDTH = fifo_write_arbiter_pkg::DEFAULT_WIDTH,
  parameter int NREQ  = fifo_write_arbiter_pkg::DEFAULT_NREQ
);

  // A word moves from requester i when req_valid[i] and req_ready[i] are both
  // high at a rising clk edge; fifo_write_en pulses in that same cycle.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_write_en;
  logic [WIDTH-1:0]      fifo_data_in;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_owner.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last_owner,
  output logic [NREQ-1:0] winner_onehot,
  output logic            found
);

  logic [LW-1:0] idx;

  // k runs 1..NREQ so last_owner itself is the final candidate.
  always_comb begin
    winner_onehot = '0;
    found         = 1'b0;
    idx           = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_owner) + k) % NREQ);
      if (!found && req[idx]) begin
        winner_onehot[idx] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Grants one requester at a time a burst of up to MAX_BURST FIFO writes,
// rotating ownership round-robin with no idle bubble between bursts.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NREQ      = DEFAULT_NREQ,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fifo_write_arbiter_if.slave  bus,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output dbg_t                 dbg
);

  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [LW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] winner;
  logic            found;
  logic [LW-1:0]   win_idx;
  logic [NREQ-1:0] ready;
  logic            write_en;
  logic            owner_valid;
  logic            burst_end;
  logic [WIDTH-1:0] data_sel;

  // One picker serves both the IDLE path and the burst-end path; last_q
  // always equals the current owner while in BURST.
  rr_pick #(.NREQ(NREQ), .LW(LW)) u_rr_pick (
    .req           (bus.req_valid),
    .last_owner    (last_q),
    .winner_onehot (winner),
    .found         (found)
  );

  always_comb begin
    win_idx  = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i])  win_idx  = LW'(i);
      if (grant_q[i]) data_sel = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign ready       = (state_q == BURST && !bus.fifo_full) ? grant_q : '0;
  assign write_en    = |(bus.req_valid & ready);
  assign owner_valid = |(bus.req_valid & grant_q);

  assign bus.req_ready     = ready;
  assign bus.fifo_write_en = write_en;
  assign bus.fifo_data_in  = (state_q == BURST) ? data_sel : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          grant_d = winner;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (write_en) cnt_d = cnt_q + CW'(1);
        // A stalled owner (fifo_full) keeps the grant as long as it stays valid.
        burst_end = !owner_valid || (write_en && cnt_q == CW'(MAX_BURST - 1));
        if (burst_end) begin
          cnt_d = '0;
          if (found) begin
            grant_d = winner;
            last_d  = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant         = grant_q;
  assign busy          = (state_q == BURST);
  assign dbg.state     = state_q;
  assign dbg.burst_cnt = DBG_CNT_W'(cnt_q);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomised checks of fifo_write_arbiter with default parameters.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int WIDTH     = 6;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int MAX_WAIT  = (NREQ - 1) * MAX_BURST;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] grant;
  logic            busy;
  dbg_t            dbg;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy),
    .dbg     (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_index_data();
    logic [NREQ*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = WIDTH'(i);
    bus.req_data = v;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n       = 1'b0;
    bus.fifo_full = 1'b0;
    bus.req_valid = 4'b1111;
    load_index_data();
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    n_checks++; if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", bus.fifo_write_en); end
    n_checks++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected IDLE", dbg.state); end
    n_checks++; if (dbg.burst_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dbg.burst_cnt); end
    n_checks++; if (bus.fifo_data_in !== 6'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.fifo_data_in); end
    reset_n = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL release_lag: got %b expected 0000", grant); end
    step();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL first_winner: got %b expected 0001", grant); end
  endtask

  task automatic test_single_owner();
    do_reset();
    load_index_data();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_lag: got %b expected 0000", grant); end
    n_checks++; if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL single_lag_wen: got %b expected 0", bus.fifo_write_en); end
    step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant[%0d]: got %b expected 0001", i, grant); end
      n_checks++; if (dbg.burst_cnt !== 5'(i % MAX_BURST)) begin n_fail++; $display("FAIL single_cnt[%0d]: got %0d expected %0d", i, dbg.burst_cnt, i % MAX_BURST); end
      n_checks++; if (bus.fifo_write_en !== 1'b1) begin n_fail++; $display("FAIL single_wen[%0d]: got %b expected 1", i, bus.fifo_write_en); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b expected 1", i, busy); end
      step();
    end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] exp_g;
    do_reset();
    load_index_data();
    bus.req_valid = 4'b1111;
    step();
    for (int i = 0; i < 16; i++) begin
      exp_g = 4'(1 << (i / MAX_BURST));
      @(negedge clk);
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rot_grant[%0d]: got %b expected %b", i, grant, exp_g); end
      n_checks++; if (bus.fifo_data_in !== 6'(i / MAX_BURST)) begin n_fail++; $display("FAIL rot_data[%0d]: got %0d expected %0d", i, bus.fifo_data_in, i / MAX_BURST); end
      n_checks++; if (bus.fifo_write_en !== 1'b1) begin n_fail++; $display("FAIL rot_wen[%0d]: got %b expected 1", i, bus.fifo_write_en); end
      step();
    end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rot_wrap: got %b expected 0001", grant); end
  endtask

  task automatic test_owner_drop();
    do_reset();
    load_index_data();
    bus.req_valid = 4'b0101;
    step();
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL drop_grant0: got %b expected 0001", grant); end
    step();
    step();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (dbg.burst_cnt !== 5'd2) begin n_fail++; $display("FAIL drop_cnt2: got %0d expected 2", dbg.burst_cnt); end
    n_checks++; if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL drop_wen: got %b expected 0", bus.fifo_write_en); end
    step();
    @(negedge clk);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL drop_regrant: got %b expected 0100", grant); end
    n_checks++; if (dbg.burst_cnt !== 5'd0) begin n_fail++; $display("FAIL drop_cnt0: got %0d expected 0", dbg.burst_cnt); end
    n_checks++; if (bus.fifo_data_in !== 6'd2) begin n_fail++; $display("FAIL drop_data: got %0d expected 2", bus.fifo_data_in); end
    n_checks++; if (bus.fifo_write_en !== 1'b1) begin n_fail++; $display("FAIL drop_wen2: got %b expected 1", bus.fifo_write_en); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    load_index_data();
    bus.req_valid = 4'b0011;
    step();
    step();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL full_wen[%0d]: got %b expected 0", i, bus.fifo_write_en); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected 0000", i, bus.req_ready); end
      n_checks++; if (dbg.burst_cnt !== 5'd1) begin n_fail++; $display("FAIL full_cnt[%0d]: got %0d expected 1", i, dbg.burst_cnt); end
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL full_grant[%0d]: got %b expected 0001", i, grant); end
      step();
    end
    bus.fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.fifo_write_en !== 1'b1) begin n_fail++; $display("FAIL resume_wen[%0d]: got %b expected 1", k, bus.fifo_write_en); end
      n_checks++; if (dbg.burst_cnt !== 5'(1 + k)) begin n_fail++; $display("FAIL resume_cnt[%0d]: got %0d expected %0d", k, dbg.burst_cnt, 1 + k); end
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL resume_grant[%0d]: got %b expected 0001", k, grant); end
      step();
    end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL full_next_owner: got %b expected 0010", grant); end
    n_checks++; if (dbg.burst_cnt !== 5'd0) begin n_fail++; $display("FAIL full_next_cnt: got %0d expected 0", dbg.burst_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load_index_data();
    bus.req_valid = 4'b1111;
    step();
    step();
    step();
    #2;
    n_checks++; if (dbg.burst_cnt !== 5'd2) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 2", dbg.burst_cnt); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant: got %b expected 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL mid_wen: got %b expected 0", bus.fifo_write_en); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b expected 0000", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: got %b expected 0001", grant); end
    n_checks++; if (dbg.burst_cnt !== 5'd0) begin n_fail++; $display("FAIL mid_regrant_cnt: got %0d expected 0", dbg.burst_cnt); end
  endtask

  // Each requester sends {id, seq}; the scoreboard expects seq in order per id.
  task automatic test_stress();
    int                    sent [NREQ];
    int                    rcvd [NREQ];
    int                    wait_cnt [NREQ];
    logic [WIDTH-1:0]      exp_q[$];
    logic [NREQ-1:0]       acc;
    logic [NREQ-1:0]       vld;
    logic [NREQ*WIDTH-1:0] v;
    logic [WIDTH-1:0]      d;
    logic [WIDTH-1:0]      exp_w;
    int                    r;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin sent[i] = 0; rcvd[i] = 0; wait_cnt[i] = 0; end
    vld = 4'($urandom_range(0, 15));
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = {2'(i), 4'(sent[i])};
    bus.req_valid = vld;
    bus.req_data  = v;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      n_checks++; if (bus.fifo_write_en !== (|acc)) begin n_fail++; $display("FAIL st_wen[%0d]: got %b expected %b", c, bus.fifo_write_en, |acc); end
      n_checks++; if ($countones(acc) > 1) begin n_fail++; $display("FAIL st_onehot[%0d]: got %b expected at most one bit", c, acc); end
      if (bus.fifo_write_en === 1'b1) begin
        d = bus.fifo_data_in;
        r = int'(d[5:4]);
        exp_q.push_back({2'(r), 4'(rcvd[r])});
        exp_w = exp_q.pop_front();
        n_checks++; if (acc !== 4'(1 << r)) begin n_fail++; $display("FAIL st_src[%0d]: got accept %b expected %b", c, acc, 4'(1 << r)); end
        n_checks++; if (d !== exp_w) begin n_fail++; $display("FAIL st_order[%0d]: got %h expected %h", c, d, exp_w); end
        rcvd[r]++;
        for (int i = 0; i < NREQ; i++) begin
          if (acc[i]) wait_cnt[i] = 0;
          else if (bus.req_valid[i]) wait_cnt[i]++;
          n_checks++; if (wait_cnt[i] > MAX_WAIT) begin n_fail++; $display("FAIL st_starve[%0d]: req %0d waited %0d expected <= %0d", c, i, wait_cnt[i], MAX_WAIT); end
        end
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          sent[i]++;
          vld[i] = ($urandom_range(0, 3) != 0);
        end else if (!vld[i]) begin
          vld[i] = ($urandom_range(0, 2) == 0);
        end
        if (!vld[i]) wait_cnt[i] = 0;
        v[i*WIDTH +: WIDTH] = {2'(i), 4'(sent[i])};
      end
      bus.req_valid = vld;
      bus.req_data  = v;
      bus.fifo_full = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < NREQ; i++) begin
      n_checks++; if (rcvd[i] !== sent[i]) begin n_fail++; $display("FAIL st_count[%0d]: written %0d expected %0d", i, rcvd[i], sent[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_owner();
    test_rotation();
    test_owner_drop();
    test_fifo_full();
    test_reset_mid_burst();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
